// File: rtl/gap_channel_scheduler_pkg.sv
// Shared types and constants for the global-average-pooling channel scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SCALE  = 2'd2,
    EMIT   = 2'd3
  } gap_state_e;

  localparam int DEF_IMG_W    = 14;
  localparam int DEF_IMG_H    = 14;
  localparam int TOTAL_PIXELS = DEF_IMG_W * DEF_IMG_H;

  // 255*256 still fits SUM_W; 16-bit sum times 8-bit reciprocal fits PROD_W.
  localparam int SUM_W  = 16;
  localparam int PROD_W = 24;
  // Pixel counter; one spare bit keeps 256-pixel maps representable.
  localparam int CNT_W  = 9;

  localparam int DEF_RECIP = 167;  // round(2^15 / 196)
  localparam int DEF_SHIFT = 15;

endpackage

// File: rtl/gap_channel_scheduler_if.sv
// Pixel-stream and result bundle between the conv stage, scheduler and classifier.
// Latency: n/a (wiring only).
// Backpressure: pix_* is valid/ready per channel; res_* is valid/ready.
interface gap_channel_scheduler_if #(
  parameter int NUM_CH = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [8*NUM_CH-1:0] pix_data;
  logic [NUM_CH-1:0]   pix_valid;
  logic [NUM_CH-1:0]   pix_ready;
  logic [7:0]          res_data;
  logic [CH_W-1:0]     res_ch;
  logic                res_valid;
  logic                res_ready;
  logic                frame_done;

  // The scheduler owns the ready side of the pixel streams and the result port.
  modport master (
    input  pix_data, pix_valid, res_ready,
    output pix_ready, res_data, res_ch, res_valid, frame_done
  );

  // Environment side: channel sources plus the result consumer.
  modport slave (
    output pix_data, pix_valid, res_ready,
    input  pix_ready, res_data, res_ch, res_valid, frame_done
  );
endinterface

// File: rtl/gap_channel_scheduler_rr_arbiter.sv
// Round-robin pick of the first requesting channel at or after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller latches the grant when it commits.
module rr_arbiter #(
  parameter int NUM_CH = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic found;
  int   pos;

  // Walk the channels starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos = (int'(ptr) + i) % NUM_CH;
      if (!found && req[pos]) begin
        found       = 1'b1;
        grant[pos]  = 1'b1;
        grant_idx   = CH_W'(pos);
      end
    end
  end

endmodule

// File: rtl/gap_channel_scheduler.sv
// Time-shares one average-pooling datapath across NUM_CH streams, one full map per grant; GAP_SCHED_ROUND_EN selects round-half-up.
// Latency: grant 1 cycle after request; result valid 2 cycles after the last accepted pixel.
// Backpressure: only the granted channel sees pix_ready; result is held until res_ready, no new grant meanwhile.
module gap_channel_scheduler
  import gap_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int RECIP  = DEF_RECIP,
  parameter int SHIFT  = DEF_SHIFT
) (
  input logic                   clk,
  input logic                   rst_n,
  gap_channel_scheduler_if.master bus
);

  localparam int                CH_W     = $clog2(NUM_CH);
  localparam int                TOT      = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TOT - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

  gap_state_e        state, state_nxt;
  logic [NUM_CH-1:0] served, served_nxt, eligible;
  logic [NUM_CH-1:0] arb_grant, grant_oh;
  logic [CH_W-1:0]   arb_idx, grant, rr_ptr;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] prod;
  logic [7:0]        pix;
  logic [7:0]        res_val;
  logic              beat, last_beat, res_hs, frame_full, frame_done_q;

  // Channels already pooled this frame are masked out of arbitration.
  assign eligible   = bus.pix_valid & ~served;
  assign pix        = 8'(bus.pix_data >> {grant, 3'b000});
  assign beat       = (state == STREAM) && |(bus.pix_valid & grant_oh);
  assign last_beat  = beat && (cnt == LAST_CNT);
  assign res_hs     = (state == EMIT) && bus.res_ready;
  assign served_nxt = served | grant_oh;
  assign frame_full = &served_nxt;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef GAP_SCHED_ROUND_EN
  localparam int              RW   = PROD_W + 1;
  localparam logic [RW-1:0]   HALF = RW'(1) << (SHIFT - 1);
  logic [RW-1:0] prod_rnd, rnd_shift;
  assign prod_rnd  = {1'b0, prod} + HALF;
  assign rnd_shift = prod_rnd >> SHIFT;
  // Rounding can carry the average past 255; clamp instead of wrapping.
  assign res_val   = (rnd_shift > RW'(255)) ? 8'hFF : rnd_shift[7:0];
`else
  assign res_val   = 8'(prod >> SHIFT);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the handshake outputs that depend only on state.
  always_comb begin
    state_nxt     = state;
    bus.pix_ready = '0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE:   if (|eligible) state_nxt = STREAM;
      STREAM: begin
        bus.pix_ready = grant_oh;
        if (last_beat) state_nxt = SCALE;
      end
      SCALE:  state_nxt = EMIT;
      EMIT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, accumulation and reciprocal scaling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      grant_oh <= '0;
      sum      <= '0;
      cnt      <= '0;
      prod     <= '0;
    end else begin
      case (state)
        IDLE: if (|eligible) begin
          grant    <= arb_idx;
          grant_oh <= arb_grant;
          sum      <= '0;
          cnt      <= '0;
        end
        STREAM: if (beat) begin
          sum <= sum + {{(SUM_W-8){1'b0}}, pix};
          cnt <= cnt + CNT_W'(1);
        end
        SCALE: prod <= PROD_W'(sum) * PROD_W'(RECIP);
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: mark served, advance the round-robin pointer, pulse on frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served       <= '0;
      rr_ptr       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= res_hs && frame_full;
      if (res_hs) begin
        served <= frame_full ? '0 : served_nxt;
        rr_ptr <= (grant == LAST_CH) ? '0 : grant + CH_W'(1);
      end
    end
  end

  // prod only changes in SCALE, so the result is stable throughout EMIT.
  assign bus.res_data   = res_val;
  assign bus.res_ch     = grant;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_gap_channel_scheduler.sv
// Directed bench for gap_channel_scheduler: per-channel sources, result logger, hand-derived averages.
// Latency: checks grant latency, result latency and frame_done timing.
// Backpressure: exercises pix_valid gaps and res_ready held low.
module tb_gap_channel_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gap_channel_scheduler_if #(.NUM_CH(8)) bus();

  gap_channel_scheduler #(
    .NUM_CH(8), .IMG_W(14), .IMG_H(14), .RECIP(167), .SHIFT(15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int ch;
    int data;
    int beats;
    int cyc;
  } res_t;

  res_t res_q[$];
  res_t last_res;
  int   remaining[8];
  int   val[8];
  bit   gap_en;
  bit   res_rdy;
  int   cyc, cur_beats, lb_cyc, rv_cyc, hs_cyc, fd_cnt, fd_cyc, multi_err;
  bit   rv_prev;
  int   n_chk, n_pass;
  int   ord6[7] = '{3, 4, 5, 6, 7, 0, 2};

  // 196*167/2^15 = 0.99890: truncation gives v-1 for any v in 1..255, rounding gives v.
  function automatic int exp_avg(input int v);
`ifdef GAP_SCHED_ROUND_EN
    return v;
`else
    return (v == 0) ? 0 : v - 1;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pix_ready"}, int'(bus.pix_ready), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_data"},  int'(bus.res_data), 0);
    chk({tag, "_res_ch"},    int'(bus.res_ch), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
  endtask

  task automatic check_res(input string tag, input int ch, input int v);
    res_t r;
    chk({tag, "_avail"}, int'(res_q.size() > 0), 1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      chk({tag, "_ch"}, r.ch, ch);
      chk({tag, "_data"}, r.data, exp_avg(v));
      chk({tag, "_beats"}, r.beats, 196);
      last_res = r;
    end
  endtask

  task automatic wait_res(input int n);
    for (int i = 0; i < 3000 && res_q.size() < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) remaining[c] = 0;
    gap_en  = 1'b0;
    res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    cur_beats = 0;
    res_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sources: each channel offers its constant pixel while it still owes beats.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 8; c++) begin
      bus.pix_valid[c] = (remaining[c] > 0) && !(gap_en && ($urandom_range(0, 2) == 0));
      bus.pix_data[c*8 +: 8] = 8'(val[c]);
    end
    bus.res_ready = res_rdy;
  end

  // Observer: counts accepted beats and logs result handshakes and frame pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(bus.pix_ready) > 1) multi_err++;
      for (int c = 0; c < 8; c++) begin
        if (bus.pix_valid[c] && bus.pix_ready[c]) begin
          cur_beats++;
          remaining[c]--;
          if (remaining[c] == 0) lb_cyc = cyc;
        end
      end
      if (bus.res_valid && !rv_prev) rv_cyc = cyc;
      if (bus.res_valid && bus.res_ready) begin
        res_q.push_back('{ch: int'(bus.res_ch), data: int'(bus.res_data), beats: cur_beats, cyc: cyc});
        cur_beats = 0;
        hs_cyc    = cyc;
      end
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    rv_prev = bus.res_valid;
  end

  initial begin
    int fd0, unstable, h_data, h_ch, h_beats, nres;
    for (int c = 0; c < 8; c++) begin
      remaining[c] = 0;
      val[c]       = 0;
    end
    gap_en = 1'b0; res_rdy = 1'b1;
    cyc = 0; cur_beats = 0; lb_cyc = 0; rv_cyc = 0; hs_cyc = 0;
    fd_cnt = 0; fd_cyc = 0; multi_err = 0; rv_prev = 1'b0;
    n_chk = 0; n_pass = 0;

    #1 rst_n = 1'b0;
    #2 chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // Single channel at full scale, plus grant and result latency.
    val[0] = 255; remaining[0] = 196;
    @(posedge clk); #2;
    chk("grant_pre_valid", int'(bus.pix_valid[0]), 1);
    chk("grant_pre_ready", int'(bus.pix_ready[0]), 0);
    @(posedge clk); #2;
    chk("grant_lat", int'(bus.pix_ready), 1);
    wait_res(1);
    chk("res_lat", rv_cyc - lb_cyc, 2);
    check_res("ch0_255", 0, 255);

    // Mid-scale and zero maps, granted in pointer order.
    val[3] = 100; val[5] = 0;
    remaining[3] = 196; remaining[5] = 196;
    wait_res(2);
    check_res("ch3_100", 3, 100);
    check_res("ch5_0", 5, 0);

    // All channels request together on a fresh frame.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      val[c] = 10 * (c + 1);
      remaining[c] = 196;
    end
    fd0 = fd_cnt;
    wait_res(8);
    for (int c = 0; c < 8; c++) check_res("all8", c, 10 * (c + 1));
    repeat (3) @(posedge clk);
    #2;
    chk("fd_once", fd_cnt - fd0, 1);
    chk("fd_lat", fd_cyc - hs_cyc, 1);

    // Valid gaps and a result consumer that stalls for 10 cycles.
    gap_en = 1'b1; res_rdy = 1'b0;
    val[1] = 77; val[2] = 33;
    remaining[1] = 196; remaining[2] = 196;
    for (int i = 0; i < 3000 && !bus.res_valid; i++) begin
      @(posedge clk); #2;
    end
    chk("hold_valid", int'(bus.res_valid), 1);
    h_data = int'(bus.res_data); h_ch = int'(bus.res_ch); h_beats = cur_beats;
    chk("hold_ch", h_ch, 1);
    unstable = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (!bus.res_valid || int'(bus.res_data) != h_data || int'(bus.res_ch) != h_ch || cur_beats != h_beats)
        unstable++;
    end
    chk("hold_stable", unstable, 0);
    res_rdy = 1'b1;
    wait_res(2);
    gap_en = 1'b0;
    check_res("gap_ch1", 1, 77);
    check_res("gap_ch2", 2, 33);
    chk("onehot_ready", multi_err, 0);

    // Channel 2 re-requests after being served; it must wait for the frame to close.
    fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) begin
      val[ord6[i]] = 5 * ord6[i] + 3;
      remaining[ord6[i]] = 196;
    end
    wait_res(7);
    for (int i = 0; i < 7; i++) check_res("reserve", ord6[i], 5 * ord6[i] + 3);
    chk("ch2_after_fd", int'(last_res.cyc > fd_cyc), 1);
    chk("fd_reserve", fd_cnt - fd0, 1);

    // Reset in the middle of a stream discards the partial map.
    do_reset();
    val[1] = 200; remaining[1] = 196;
    for (int i = 0; i < 3000 && remaining[1] > 96; i++) begin
      @(posedge clk); #2;
    end
    chk("mid_beats_left", remaining[1], 96);
    nres = res_q.size();
    rst_n = 1'b0;
    remaining[1] = 0;
    #1 chk_reset_outs("midrst");
    repeat (2) @(posedge clk);
    #2;
    cur_beats = 0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_no_res", res_q.size(), nres);
    val[1] = 50; remaining[1] = 196;
    wait_res(1);
    check_res("post_rst", 1, 50);
    chk("onehot_ready_end", multi_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
